// File: rtl/grf_scoreboard_if.sv
// Decode-side bundle between the D stage and the hazard scoreboard.
// The decoder drives the master side; the scoreboard is the slave side.
interface grf_scoreboard_if #(
  parameter int unsigned CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [1:0]       id_tuse_rs;
  logic [1:0]       id_tuse_rt;
  logic [4:0]       id_rd;
  logic [1:0]       id_tnew;
  logic             stall;
  logic [1:0]       rs_stage;
  logic [1:0]       rt_stage;
  logic             rs_ready;
  logic             rt_ready;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_rd, id_tnew,
    input  stall, rs_stage, rt_stage, rs_ready, rt_ready, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_rd, id_tnew,
    output stall, rs_stage, rt_stage, rs_ready, rt_ready, stall_cnt
  );
endinterface

// File: rtl/grf_scoreboard.sv
// Register-file hazard scoreboard: tracks the newest in-flight writer and its
// remaining Tnew per GPR, raises stall against decode Tuse, reports bypass source.
module grf_scoreboard #(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  grf_scoreboard_if.slave   sb
);

  localparam int unsigned NREG = 32;

  logic [1:0]       r_stg [NREG];
  logic [1:0]       r_tn  [NREG];
  logic [CNT_W-1:0] r_stall_cnt;

  logic [1:0] w_rs_stage;
  logic [1:0] w_rt_stage;
  logic       w_rs_ready;
  logic       w_rt_ready;
  logic       w_haz_rs;
  logic       w_haz_rt;
  logic       w_stall;
  logic       w_issue;

  // Source lookup and hazard detection; r0 is never tracked.
  always_comb begin
    w_rs_stage = 2'd0;
    w_rt_stage = 2'd0;
    if (sb.id_rs != 5'd0) w_rs_stage = r_stg[sb.id_rs];
    if (sb.id_rt != 5'd0) w_rt_stage = r_stg[sb.id_rt];
    w_rs_ready = (w_rs_stage == 2'd0) || (r_tn[sb.id_rs] == 2'd0);
    w_rt_ready = (w_rt_stage == 2'd0) || (r_tn[sb.id_rt] == 2'd0);
    w_haz_rs   = sb.id_valid && (w_rs_stage != 2'd0) && (r_tn[sb.id_rs] > sb.id_tuse_rs);
    w_haz_rt   = sb.id_valid && (w_rt_stage != 2'd0) && (r_tn[sb.id_rt] > sb.id_tuse_rt);
    w_stall    = w_haz_rs || w_haz_rt;
    w_issue    = sb.id_valid && !w_stall && (sb.id_rd != 5'd0);
  end

  // Every entry advances one stage per cycle; a new issue overrides the older writer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NREG); r++) begin
        r_stg[r] <= 2'd0;
        r_tn[r]  <= 2'd0;
      end
      r_stall_cnt <= '0;
    end else begin
      for (int r = 1; r < int'(NREG); r++) begin
        if (w_issue && (sb.id_rd == 5'(r))) begin
          r_stg[r] <= 2'd1;
          r_tn[r]  <= sb.id_tnew;
        end else begin
          r_stg[r] <= ((r_stg[r] == 2'd0) || (r_stg[r] == 2'd3)) ? 2'd0 : r_stg[r] + 2'd1;
          r_tn[r]  <= (r_tn[r] == 2'd0) ? 2'd0 : r_tn[r] - 2'd1;
        end
      end
      r_stg[0] <= 2'd0;
      r_tn[0]  <= 2'd0;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign sb.stall     = w_stall;
  assign sb.rs_stage  = w_rs_stage;
  assign sb.rt_stage  = w_rt_stage;
  assign sb.rs_ready  = w_rs_ready;
  assign sb.rt_ready  = w_rt_ready;
  assign sb.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Bench for grf_scoreboard: directed pipeline scenarios plus random traffic,
// checked against a cycle-stamped write-list model through an expectation queue.
module tb_grf_scoreboard;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  grf_scoreboard_if #(.CNT_W(CNT_W)) bus ();

  grf_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rd;
    int cyc;
    int tnew;
  } wr_t;

  typedef struct {
    int stall;
    int rss;
    int rts;
    int rsr;
    int rtr;
    int cnt;
    int cyc;
  } exp_t;

  wr_t  wq[$];
  exp_t exp_q[$];
  int   cyc;
  int   m_cnt;
  bit   model_ok;
  int   n_cmp;
  int   n_bad;

  // Newest in-flight write to reg: stage = its age (1..3), tn = tnew minus elapsed cycles.
  task automatic lookup(input int reg_n, output int stg, output int tn);
    stg = 0;
    tn  = 0;
    if (reg_n != 0) begin
      foreach (wq[i]) begin
        int age;
        age = cyc - wq[i].cyc;
        if (wq[i].rd == reg_n && age >= 1 && age <= 3) begin
          stg = age;
          tn  = wq[i].tnew - (age - 1);
          if (tn < 0) tn = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input int got, input int want, input int at);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, at, got, want);
    end
  endtask

  // One D-stage cycle: drive, predict, let the edge happen, update the model.
  task automatic step(input bit v, input int rs, input int rt, input int tu_rs,
                      input int tu_rt, input int rd, input int tnew, input bit r);
    int s_rs, t_rs, s_rt, t_rt, st;
    exp_t e;
    bus.id_valid   = v;
    bus.id_rs      = 5'(rs);
    bus.id_rt      = 5'(rt);
    bus.id_tuse_rs = 2'(tu_rs);
    bus.id_tuse_rt = 2'(tu_rt);
    bus.id_rd      = 5'(rd);
    bus.id_tnew    = 2'(tnew);
    rst            = r;
    lookup(rs, s_rs, t_rs);
    lookup(rt, s_rt, t_rt);
    st = (v && s_rs != 0 && t_rs > tu_rs) || (v && s_rt != 0 && t_rt > tu_rt) ? 1 : 0;
    if (model_ok) begin
      e.stall = st;
      e.rss   = s_rs;
      e.rts   = s_rt;
      e.rsr   = (s_rs == 0 || t_rs == 0) ? 1 : 0;
      e.rtr   = (s_rt == 0 || t_rt == 0) ? 1 : 0;
      e.cnt   = m_cnt;
      e.cyc   = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      wq.delete();
      m_cnt    = 0;
      model_ok = 1'b1;
    end else begin
      if (st != 0 && m_cnt < CNT_MAX) m_cnt++;
      if (v && st == 0 && rd != 0) wq.push_back('{rd: rd, cyc: cyc, tnew: tnew});
    end
    cyc++;
    while (wq.size() > 0 && cyc - wq[0].cyc > 3) void'(wq.pop_front());
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 0, 0, 3, 3, 0, 0, 1'b1);
  endtask

  // Monitor: outputs are valid every cycle, so each falling edge consumes one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("stall",     int'(bus.stall),     e.stall, e.cyc);
        check("rs_stage",  int'(bus.rs_stage),  e.rss,   e.cyc);
        check("rt_stage",  int'(bus.rt_stage),  e.rts,   e.cyc);
        check("rs_ready",  int'(bus.rs_ready),  e.rsr,   e.cyc);
        check("rt_ready",  int'(bus.rt_ready),  e.rtr,   e.cyc);
        check("stall_cnt", int'(bus.stall_cnt), e.cnt,   e.cyc);
      end
    end
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    cyc      = 0;
    m_cnt    = 0;
    model_ok = 1'b0;
    rst      = 1'b1;
    bus.id_valid = 1'b0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_tuse_rs = 2'd3; bus.id_tuse_rt = 2'd3; bus.id_tnew = '0;
    @(posedge clk);
    #1;

    // Clean state read after reset.
    do_reset();
    step(1'b1, 5, 6, 0, 0, 0, 0, 1'b0);

    // Load followed by a branch-style consumer: two stall cycles.
    do_reset();
    step(1'b1, 0, 0, 3, 3, 8, 2, 1'b0);
    repeat (3) step(1'b1, 8, 0, 0, 3, 0, 0, 1'b0);
    step(1'b0, 0, 0, 3, 3, 0, 0, 1'b0);

    // Load followed by an E-stage consumer: one stall cycle.
    do_reset();
    step(1'b1, 0, 0, 3, 3, 8, 2, 1'b0);
    repeat (3) step(1'b1, 8, 0, 1, 3, 0, 0, 1'b0);

    // Newest producer wins over an older ALU write to the same register.
    do_reset();
    step(1'b1, 0, 0, 3, 3, 9, 1, 1'b0);
    step(1'b1, 0, 0, 3, 3, 9, 0, 1'b0);
    step(1'b1, 0, 9, 3, 0, 0, 0, 1'b0);
    step(1'b1, 0, 9, 3, 0, 0, 0, 1'b0);

    // r0 is never tracked; reset drops a pending load.
    do_reset();
    step(1'b1, 0, 0, 3, 3, 0, 2, 1'b0);
    step(1'b1, 0, 0, 0, 0, 0, 0, 1'b0);
    step(1'b1, 0, 0, 3, 3, 8, 2, 1'b0);
    step(1'b1, 8, 0, 0, 3, 0, 0, 1'b1);
    step(1'b1, 8, 0, 0, 3, 0, 0, 1'b0);

    // Back-to-back dependent loads drive the stall counter into saturation.
    do_reset();
    repeat (30) step(1'b1, 8, 0, 0, 3, 8, 2, 1'b0);
    step(1'b0, 0, 0, 3, 3, 0, 0, 1'b0);

    // Random traffic on a small register window to keep hazards frequent.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bit v, r;
      v = ($urandom_range(9, 0) < 8);
      r = ($urandom_range(63, 0) == 0);
      step(v, int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
           int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
           int'($urandom_range(7, 0)), int'($urandom_range(2, 0)), r);
    end

    repeat (2) @(negedge clk);
    check("drain", exp_q.size(), 0, cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
